// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the cache data array.
// Contents: WORD_BITS, evict_state_t, first_word_index(), word_popcount().
package cache_pkg;

    localparam int WORD_BITS = 16;
    localparam int MAX_WORDS = 32;

    typedef enum logic [1:0] {EV_IDLE, EV_READ, EV_OFFER} evict_state_t;

    // Index of the lowest word with any enabled byte; 0 for an empty mask.
    function automatic int first_word_index(input logic [2*MAX_WORDS-1:0] mask, input int words);
        first_word_index = 0;
        for (int i = MAX_WORDS - 1; i >= 0; i--)
            if (i < words && mask[2*i +: 2] != 2'b00) first_word_index = i;
    endfunction

    // Number of words with at least one enabled byte.
    function automatic int word_popcount(input logic [2*MAX_WORDS-1:0] mask, input int words);
        word_popcount = 0;
        for (int i = 0; i < MAX_WORDS; i++)
            if (i < words && mask[2*i +: 2] != 2'b00) word_popcount++;
    endfunction

endpackage

// File: rtl/cache_data_array_if.sv
// cache_data_array_if: access, fill and eviction signals of the cache data array.
// Modports: slave (the data array), master (load/store unit + DRAM controller side).
interface cache_data_array_if #(
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 512,
    parameter int WORDS_PER_LINE = 8
);
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int SET_W     = $clog2(NUM_SETS);
    localparam int LINE_BITS = 16 * WORDS_PER_LINE;
    localparam int BYTES     = 2 * WORDS_PER_LINE;
    localparam int WC_W      = $clog2(WORDS_PER_LINE) + 1;

    logic [SET_W-1:0]     target_set;
    logic [WAY_W-1:0]     target_way_read;
    logic [WAY_W-1:0]     target_way_write;
    logic [BYTES-1:0]     access_mask;
    logic [LINE_BITS-1:0] access_in_data;
    logic [LINE_BITS-1:0] fill_data;
    logic                 do_full_write;
    logic                 do_partial_write;
    logic                 override_no_write;
    logic                 do_byte_operation;
    logic                 hold;
    logic [LINE_BITS-1:0] raw_out_data;
    logic [LINE_BITS-1:0] single_out_data;
    logic [WC_W-1:0]      word_count;
    logic                 out_dirty;
    logic                 read_port_busy;
    logic                 evict_req;
    logic [SET_W-1:0]     evict_set;
    logic [WAY_W-1:0]     evict_way;
    logic                 evict_busy;
    logic                 evict_valid;
    logic                 evict_ready;
    logic [LINE_BITS-1:0] evict_data;
    logic                 evict_dirty;

    modport slave (
        input  target_set, target_way_read, target_way_write, access_mask, access_in_data,
               fill_data, do_full_write, do_partial_write, override_no_write,
               do_byte_operation, hold, evict_req, evict_set, evict_way, evict_ready,
        output raw_out_data, single_out_data, word_count, out_dirty, read_port_busy,
               evict_busy, evict_valid, evict_data, evict_dirty
    );

    modport master (
        output target_set, target_way_read, target_way_write, access_mask, access_in_data,
               fill_data, do_full_write, do_partial_write, override_no_write,
               do_byte_operation, hold, evict_req, evict_set, evict_way, evict_ready,
        input  raw_out_data, single_out_data, word_count, out_dirty, read_port_busy,
               evict_busy, evict_valid, evict_data, evict_dirty
    );

endinterface

// File: rtl/cache_line_ram.sv
// cache_line_ram: one-read/one-write byte-enabled line RAM with registered, read-enabled output.
// Ports: main_clk, re/raddr (read), we/waddr/be/wdata (write), rdata (1-cycle latency).
// CACHE_DATA_BYPASS_EN: a same-address write forwards its enabled bytes to rdata.
module cache_line_ram #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11,
    parameter int BYTES  = 16
) (
    input  logic                main_clk,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [BYTES-1:0]    be,
    input  logic [8*BYTES-1:0]  wdata,
    output logic [8*BYTES-1:0]  rdata
);
    logic [8*BYTES-1:0] mem [DEPTH];
    logic [8*BYTES-1:0] rd_next;

`ifdef CACHE_DATA_BYPASS_EN
    always_comb begin
        rd_next = mem[raddr];
        for (int i = 0; i < BYTES; i++)
            if (we && be[i] && waddr == raddr) rd_next[8*i +: 8] = wdata[8*i +: 8];
    end
`else
    assign rd_next = mem[raddr];
`endif

    always_ff @(posedge main_clk) begin
        for (int i = 0; i < BYTES; i++)
            if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        if (re) rdata <= rd_next;
    end

endmodule

// File: rtl/cache_data_array.sv
// cache_data_array: set-associative line store with dirty tracking, aligned read extraction
// and a victim-eviction engine (valid/ready) for write-back.
// Ports: main_clk, main_reset_n (async, active low), bus (cache_data_array_if.slave).
// CACHE_DATA_BYPASS_EN: same-cycle write+read of one line returns the merged new line/dirty bit.
module cache_data_array
    import cache_pkg::*;
#(
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 512,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic main_clk,
    input  logic main_reset_n,
    cache_data_array_if.slave bus
);
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int SET_W     = $clog2(NUM_SETS);
    localparam int LINE_BITS = WORD_BITS * WORDS_PER_LINE;
    localparam int BYTES     = 2 * WORDS_PER_LINE;
    localparam int ADDR_W    = WAY_W + SET_W;
    localparam int DEPTH     = NUM_WAYS * NUM_SETS;
    localparam int WOFF_W    = $clog2(WORDS_PER_LINE);
    localparam int WC_W      = $clog2(WORDS_PER_LINE) + 1;

    evict_state_t         state;
    logic [SET_W-1:0]     ev_set;
    logic [WAY_W-1:0]     ev_way;
    logic                 fresh;
    logic [LINE_BITS-1:0] evict_q;
    logic [DEPTH-1:0]     dirty;
    logic                 do_write, rd_en, handshake;
    logic [ADDR_W-1:0]    w_addr, r_addr, ev_addr;
    logic [BYTES-1:0]     be;
    logic [LINE_BITS-1:0] w_data, ram_rdata, masked, shifted;
    logic [BYTES-1:0]     mask_r;
    logic                 byte_op_r;
    logic [WOFF_W-1:0]    word_offset_r;
    logic [2*MAX_WORDS-1:0] mask_ext;

    assign do_write  = bus.do_full_write | (bus.do_partial_write & ~bus.override_no_write & ~bus.hold);
    assign be        = bus.do_full_write ? '1 : bus.access_mask;
    assign w_data    = bus.do_full_write ? bus.fill_data : bus.access_in_data;
    assign w_addr    = {bus.target_way_write, bus.target_set};
    assign ev_addr   = {ev_way, ev_set};
    // The eviction read steals the port for one cycle regardless of hold.
    assign rd_en     = state == EV_READ || !bus.hold;
    assign r_addr    = state == EV_READ ? ev_addr : {bus.target_way_read, bus.target_set};
    assign handshake = state == EV_OFFER && bus.evict_valid && bus.evict_ready;
    assign mask_ext  = (2*MAX_WORDS)'(bus.access_mask);

    cache_line_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYTES(BYTES)) u_ram (
        .main_clk (main_clk),
        .re       (rd_en),
        .raddr    (r_addr),
        .we       (do_write),
        .waddr    (w_addr),
        .be       (be),
        .wdata    (w_data),
        .rdata    (ram_rdata)
    );

    for (genvar b = 0; b < BYTES; b++) begin : g_mask
        assign masked[8*b +: 8] = ram_rdata[8*b +: 8] & {8{mask_r[b]}};
    end

    assign shifted             = masked >> (32'(word_offset_r) * WORD_BITS);
    assign bus.single_out_data = byte_op_r ? {shifted[LINE_BITS-1:16], 8'h00, shifted[15:8] | shifted[7:0]} : shifted;
    assign bus.raw_out_data    = ram_rdata;
    // First offer cycle still sees the victim on the RAM output; afterwards the captured copy.
    assign bus.evict_data      = fresh ? ram_rdata : evict_q;

    // A write in the handshake cycle overrides the eviction clear (last assignment wins).
    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            dirty <= '0;
        end else begin
            if (handshake) dirty[ev_addr] <= 1'b0;
            if (do_write) dirty[w_addr] <= !bus.do_full_write;
        end
    end

    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            bus.out_dirty  <= 1'b0;
            bus.word_count <= '0;
            mask_r         <= '0;
            byte_op_r      <= 1'b0;
            word_offset_r  <= '0;
        end else begin
`ifdef CACHE_DATA_BYPASS_EN
            if (rd_en) bus.out_dirty <= (do_write && w_addr == r_addr) ? !bus.do_full_write : dirty[r_addr];
`else
            if (rd_en) bus.out_dirty <= dirty[r_addr];
`endif
            if (!bus.hold) begin
                mask_r         <= bus.access_mask;
                byte_op_r      <= bus.do_byte_operation;
                word_offset_r  <= WOFF_W'(first_word_index(mask_ext, WORDS_PER_LINE));
                bus.word_count <= WC_W'(word_popcount(mask_ext, WORDS_PER_LINE));
            end
        end
    end

    always_ff @(posedge main_clk or negedge main_reset_n) begin
        if (!main_reset_n) begin
            state              <= EV_IDLE;
            ev_set             <= '0;
            ev_way             <= '0;
            fresh              <= 1'b0;
            evict_q            <= '0;
            bus.evict_dirty    <= 1'b0;
            bus.evict_valid    <= 1'b0;
            bus.evict_busy     <= 1'b0;
            bus.read_port_busy <= 1'b0;
        end else begin
            case (state)
                EV_IDLE: if (bus.evict_req && !bus.hold) begin
                    ev_set             <= bus.evict_set;
                    ev_way             <= bus.evict_way;
                    bus.read_port_busy <= 1'b1;
                    bus.evict_busy     <= 1'b1;
                    state              <= EV_READ;
                end
                EV_READ: begin
                    bus.read_port_busy <= 1'b0;
                    bus.evict_valid    <= 1'b1;
                    bus.evict_dirty    <= dirty[ev_addr];
                    fresh              <= 1'b1;
                    state              <= EV_OFFER;
                end
                EV_OFFER: begin
                    fresh <= 1'b0;
                    if (fresh) evict_q <= ram_rdata;
                    if (bus.evict_ready) begin
                        bus.evict_valid <= 1'b0;
                        bus.evict_busy  <= 1'b0;
                        state           <= EV_IDLE;
                    end
                end
                default: state <= EV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_data_array.sv
// tb_cache_data_array: directed self-checking bench for cache_data_array.
module tb_cache_data_array;

    logic main_clk = 1'b0;
    logic main_reset_n = 1'b0;
    int n_checks = 0;
    int n_err = 0;
    logic [127:0] pat, beef_line, npat, cafe_line;

    always #5 main_clk = ~main_clk;

    cache_data_array_if #(.NUM_WAYS(4), .NUM_SETS(512), .WORDS_PER_LINE(8)) bus ();

    cache_data_array #(.NUM_WAYS(4), .NUM_SETS(512), .WORDS_PER_LINE(8)) dut (
        .main_clk     (main_clk),
        .main_reset_n (main_reset_n),
        .bus          (bus.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge main_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) pat[16*i +: 16] = 16'(16'h0011 * (i + 1));
        beef_line = pat;
        beef_line[47:32] = 16'hBEEF;
        npat = ~pat;
        cafe_line = npat;
        cafe_line[15:0] = 16'hCAFE;
        bus.target_set = '0;
        bus.target_way_read = '0;
        bus.target_way_write = '0;
        bus.access_mask = '0;
        bus.access_in_data = '0;
        bus.fill_data = '0;
        bus.do_full_write = 1'b0;
        bus.do_partial_write = 1'b0;
        bus.override_no_write = 1'b0;
        bus.do_byte_operation = 1'b0;
        bus.hold = 1'b0;
        bus.evict_req = 1'b0;
        bus.evict_set = '0;
        bus.evict_way = '0;
        bus.evict_ready = 1'b0;
        cyc;
        cyc;
        chk("rst_valid", 128'(bus.evict_valid), 128'(0));
        chk("rst_busy", 128'(bus.evict_busy), 128'(0));
        chk("rst_rpb", 128'(bus.read_port_busy), 128'(0));
        chk("rst_wc", 128'(bus.word_count), 128'(0));
        chk("rst_dirty", 128'(bus.out_dirty), 128'(0));
        main_reset_n = 1'b1;
        cyc;
        // fill set 5 way 2, read it back
        bus.target_set = 5;
        bus.target_way_write = 2;
        bus.fill_data = pat;
        bus.do_full_write = 1'b1;
        cyc;
        bus.do_full_write = 1'b0;
        bus.target_way_read = 2;
        bus.access_mask = 16'hFFFF;
        cyc;
        chk("fill_raw", bus.raw_out_data, pat);
        chk("fill_dirty", 128'(bus.out_dirty), 128'(0));
        chk("fill_wc", 128'(bus.word_count), 128'(8));
        chk("fill_single", bus.single_out_data, pat);
        // partial write of word 2
        bus.access_mask = 16'h0030;
        bus.access_in_data = 128'hBEEF << 32;
        bus.do_partial_write = 1'b1;
        cyc;
        bus.do_partial_write = 1'b0;
        cyc;
        chk("pw_single", bus.single_out_data, 128'hBEEF);
        chk("pw_wc", 128'(bus.word_count), 128'(1));
        chk("pw_dirty", 128'(bus.out_dirty), 128'(1));
        chk("pw_raw", bus.raw_out_data, beef_line);
        // byte read of the high byte of word 2
        bus.do_byte_operation = 1'b1;
        bus.access_mask = 16'h0020;
        cyc;
        chk("byte_single", bus.single_out_data, 128'h00BE);
        bus.do_byte_operation = 1'b0;
        // clean line at set 7 way 0, then suppressed writes
        bus.target_set = 7;
        bus.target_way_write = 0;
        bus.fill_data = pat;
        bus.do_full_write = 1'b1;
        cyc;
        bus.do_full_write = 1'b0;
        bus.access_mask = 16'h0003;
        bus.access_in_data = 128'h1234;
        bus.do_partial_write = 1'b1;
        bus.override_no_write = 1'b1;
        cyc;
        bus.override_no_write = 1'b0;
        bus.do_partial_write = 1'b0;
        bus.target_way_read = 0;
        bus.access_mask = 16'hFFFF;
        cyc;
        chk("ovr_raw", bus.raw_out_data, pat);
        chk("ovr_dirty", 128'(bus.out_dirty), 128'(0));
        bus.hold = 1'b1;
        bus.do_partial_write = 1'b1;
        bus.access_mask = 16'h0003;
        bus.target_way_read = 2;
        cyc;
        chk("hold_raw", bus.raw_out_data, pat);
        chk("hold_wc", 128'(bus.word_count), 128'(8));
        bus.hold = 1'b0;
        bus.do_partial_write = 1'b0;
        bus.target_way_read = 0;
        bus.access_mask = 16'hFFFF;
        cyc;
        chk("hold_ram", bus.raw_out_data, pat);
        chk("hold_dirty", 128'(bus.out_dirty), 128'(0));
        // evict dirty set 5 way 2 with ready held low for 3 offer cycles
        bus.evict_set = 5;
        bus.evict_way = 2;
        bus.evict_req = 1'b1;
        cyc;
        chk("ev_rpb1", 128'(bus.read_port_busy), 128'(1));
        chk("ev_busy", 128'(bus.evict_busy), 128'(1));
        chk("ev_valid0", 128'(bus.evict_valid), 128'(0));
        bus.evict_req = 1'b0;
        cyc;
        chk("ev_rpb0", 128'(bus.read_port_busy), 128'(0));
        chk("ev_valid1", 128'(bus.evict_valid), 128'(1));
        chk("ev_data1", bus.evict_data, beef_line);
        chk("ev_dirty", 128'(bus.evict_dirty), 128'(1));
        cyc;
        chk("ev_valid2", 128'(bus.evict_valid), 128'(1));
        chk("ev_data2", bus.evict_data, beef_line);
        cyc;
        chk("ev_valid3", 128'(bus.evict_valid), 128'(1));
        chk("ev_data3", bus.evict_data, beef_line);
        bus.evict_ready = 1'b1;
        cyc;
        bus.evict_ready = 1'b0;
        chk("ev_done_valid", 128'(bus.evict_valid), 128'(0));
        chk("ev_done_busy", 128'(bus.evict_busy), 128'(0));
        chk("ev_done_rpb", 128'(bus.read_port_busy), 128'(0));
        bus.target_set = 5;
        bus.target_way_read = 2;
        cyc;
        chk("ev_clr_dirty", 128'(bus.out_dirty), 128'(0));
        chk("ev_keep_raw", bus.raw_out_data, beef_line);
        // fill of the victim line while it is being offered
        bus.evict_set = 7;
        bus.evict_way = 0;
        bus.evict_req = 1'b1;
        cyc;
        bus.evict_req = 1'b0;
        cyc;
        bus.target_set = 7;
        bus.target_way_write = 0;
        bus.fill_data = npat;
        bus.do_full_write = 1'b1;
        cyc;
        bus.do_full_write = 1'b0;
        chk("evfill_data", bus.evict_data, pat);
        chk("evfill_dirty", 128'(bus.evict_dirty), 128'(0));
        cyc;
        chk("evfill_data2", bus.evict_data, pat);
        bus.evict_ready = 1'b1;
        cyc;
        bus.evict_ready = 1'b0;
        bus.target_way_read = 0;
        bus.access_mask = 16'hFFFF;
        cyc;
        chk("evfill_after", bus.raw_out_data, npat);
        // same-cycle write and read of one line
        bus.access_mask = 16'h0003;
        bus.access_in_data = 128'hCAFE;
        bus.do_partial_write = 1'b1;
        cyc;
        bus.do_partial_write = 1'b0;
`ifdef CACHE_DATA_BYPASS_EN
        chk("same_raw", bus.raw_out_data, cafe_line);
        chk("same_dirty", 128'(bus.out_dirty), 128'(1));
`else
        chk("same_raw", bus.raw_out_data, npat);
        chk("same_dirty", 128'(bus.out_dirty), 128'(0));
`endif
        cyc;
        chk("same_next_raw", bus.raw_out_data, cafe_line);
        chk("same_next_dirty", 128'(bus.out_dirty), 128'(1));
        // reset while offering a victim
        bus.evict_set = 5;
        bus.evict_way = 2;
        bus.evict_req = 1'b1;
        cyc;
        bus.evict_req = 1'b0;
        cyc;
        chk("rst_pre_valid", 128'(bus.evict_valid), 128'(1));
        #2;
        main_reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", 128'(bus.evict_valid), 128'(0));
        chk("rst_mid_busy", 128'(bus.evict_busy), 128'(0));
        cyc;
        main_reset_n = 1'b1;
        cyc;
        chk("rst_post_valid", 128'(bus.evict_valid), 128'(0));
        chk("rst_post_dirty", 128'(bus.out_dirty), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
